// File: rtl/sync_fifo_prog_if.sv
// Handshake bundle for the single-clock programmable FIFO.
// The master (producer/consumer side) drives the write, read and error-clear requests.
// The slave (the FIFO) returns read data, status flags, occupancy and the sticky error flags.
//   w_en, din        write request and write data
//   r_en             read request (pop)
//   clr_err          synchronous clear of overflow/underflow
//   dout, dout_valid read data and its qualifier
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow                              sticky error flags
interface sync_fifo_prog_if #(
   parameter int M = 7,
   parameter int N = 3
);
   logic         w_en;
   logic [M:0]   din;
   logic         r_en;
   logic         clr_err;
   logic [M:0]   dout;
   logic         dout_valid;
   logic         full;
   logic         empty;
   logic         almost_full;
   logic         almost_empty;
   logic [N+1:0] count;
   logic         overflow;
   logic         underflow;

   modport master (
      output w_en, din, r_en, clr_err,
      input  dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  w_en, din, r_en, clr_err,
      output dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and a selectable read mode
// (registered read when FWFT=0, first-word-fall-through when FWFT=1).
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous active-high reset of pointers, count, read data and error flags
//   bus    sync_fifo_prog_if slave modport carrying the handshake, data and status
module sync_fifo_prog #(
   parameter int M      = 7,
   parameter int N      = 3,
   parameter int AF_LVL = 12,
   parameter int AE_LVL = 4,
   parameter int FWFT   = 0
) (
   input  logic            clk,
   input  logic            reset,
   sync_fifo_prog_if.slave bus
);
   localparam int DEPTH = 1 << (N + 1);
   localparam logic [N+1:0] AF_C    = (N + 2)'(AF_LVL);
   localparam logic [N+1:0] AE_C    = (N + 2)'(AE_LVL);
   localparam logic [N+1:0] PTR_ONE = {{(N + 1){1'b0}}, 1'b1};

   generate
      if (AF_LVL > DEPTH) begin : g_af_check
         $error("sync_fifo_prog: AF_LVL exceeds depth");
      end
      if (AE_LVL >= DEPTH) begin : g_ae_check
         $error("sync_fifo_prog: AE_LVL must be less than depth");
      end
   endgenerate

   logic [M:0]   mem [DEPTH];
   logic [N+1:0] wptr;
   logic [N+1:0] rptr;
   logic [N+1:0] cnt;
   logic [M:0]   dout_p1;
   logic         vld_p1;
   logic         overflow_r;
   logic         underflow_r;

   logic [N:0]   waddr;
   logic [N:0]   raddr;
   logic         full_c;
   logic         empty_c;
   logic         rd_ok;
   logic         wr_ok;

   assign waddr   = wptr[N:0];
   assign raddr   = rptr[N:0];
   // Same slot but one lap apart means every slot is occupied.
   assign full_c  = (waddr == raddr) && (wptr[N+1] != rptr[N+1]);
   assign empty_c = (wptr == rptr);

   assign rd_ok = bus.r_en & ~empty_c;
   // A pop in the same cycle frees the slot, so a write at full is still taken.
   assign wr_ok = bus.w_en & (~full_c | rd_ok);

   // Storage: no reset, contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[waddr] <= bus.din;
      end
   end

   // Stage p1: pointers, occupancy, registered read data and error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr        <= '0;
         rptr        <= '0;
         cnt         <= '0;
         dout_p1     <= '0;
         vld_p1      <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + PTR_ONE;
         end
         if (rd_ok) begin
            rptr    <= rptr + PTR_ONE;
            dout_p1 <= mem[raddr];
         end
         vld_p1 <= rd_ok;

         case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + PTR_ONE;
            2'b01:   cnt <= cnt - PTR_ONE;
            default: cnt <= cnt;
         endcase

         // A fresh error in the clearing cycle keeps the flag set.
         overflow_r  <= (overflow_r  & ~bus.clr_err) | (bus.w_en & ~wr_ok);
         underflow_r <= (underflow_r & ~bus.clr_err) | (bus.r_en & empty_c);
      end
   end

   // Output: FWFT shows the head word combinationally; standard mode shows the last pop.
   assign bus.dout         = (FWFT != 0) ? (empty_c ? '0 : mem[raddr]) : dout_p1;
   assign bus.dout_valid   = (FWFT != 0) ? ~empty_c : vld_p1;
   assign bus.full         = full_c;
   assign bus.empty        = empty_c;
   assign bus.almost_full  = (cnt >= AF_C);
   assign bus.almost_empty = (cnt <= AE_C);
   assign bus.count        = cnt;
   assign bus.overflow     = overflow_r;
   assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: one standard-mode and one FWFT instance share the
// same stimulus; a queue-based occupancy model predicts every output.
module tb_sync_fifo_prog;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       w_en = 1'b0;
   logic [7:0] din = 8'h00;
   logic       r_en = 1'b0;
   logic       clr_err = 1'b0;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   logic [7:0] q[$];
   logic       m_ov = 1'b0;
   logic       m_un = 1'b0;
   logic [7:0] m_dout = 8'h00;
   logic       m_vld = 1'b0;
   bit         m_wr;
   bit         m_rd;

   sync_fifo_prog_if #(.M(7), .N(3)) bus_std ();
   sync_fifo_prog_if #(.M(7), .N(3)) bus_fw ();

   assign bus_std.w_en    = w_en;
   assign bus_std.din     = din;
   assign bus_std.r_en    = r_en;
   assign bus_std.clr_err = clr_err;
   assign bus_fw.w_en     = w_en;
   assign bus_fw.din      = din;
   assign bus_fw.r_en     = r_en;
   assign bus_fw.clr_err  = clr_err;

   sync_fifo_prog #(.M(7), .N(3), .AF_LVL(12), .AE_LVL(4), .FWFT(0)) dut_std (
      .clk   (clk),
      .reset (rst),
      .bus   (bus_std)
   );

   sync_fifo_prog #(.M(7), .N(3), .AF_LVL(12), .AE_LVL(4), .FWFT(1)) dut_fw (
      .clk   (clk),
      .reset (rst),
      .bus   (bus_fw)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
      checks++;
   endtask

   task automatic check_all();
      int sz;
      sz = q.size();
      chk("count",        32'(bus_std.count), sz);
      chk("empty",        32'(bus_std.empty), (sz == 0));
      chk("full",         32'(bus_std.full), (sz == DEPTH));
      chk("almost_full",  32'(bus_std.almost_full), (sz >= 12));
      chk("almost_empty", 32'(bus_std.almost_empty), (sz <= 4));
      chk("overflow",     32'(bus_std.overflow), 32'(m_ov));
      chk("underflow",    32'(bus_std.underflow), 32'(m_un));
      chk("std_dout",     32'(bus_std.dout), 32'(m_dout));
      chk("std_valid",    32'(bus_std.dout_valid), 32'(m_vld));
      chk("fw_count",     32'(bus_fw.count), sz);
      chk("fw_overflow",  32'(bus_fw.overflow), 32'(m_ov));
      chk("fw_underflow", 32'(bus_fw.underflow), 32'(m_un));
      chk("fw_valid",     32'(bus_fw.dout_valid), (sz != 0));
      if (sz != 0) begin
         chk("fw_dout", 32'(bus_fw.dout), 32'(q[0]));
      end
   endtask

   // One clock: predict from the inputs present at the edge, then check after it.
   task automatic cycle();
      bit new_ov;
      bit new_un;
      if (rst) begin
         q.delete();
         m_ov   = 1'b0;
         m_un   = 1'b0;
         m_dout = 8'h00;
         m_vld  = 1'b0;
         m_wr   = 1'b0;
         m_rd   = 1'b0;
      end else begin
         m_rd   = r_en && (q.size() != 0);
         m_wr   = w_en && ((q.size() < DEPTH) || m_rd);
         new_ov = w_en && !m_wr;
         new_un = r_en && (q.size() == 0);
         if (m_rd) m_dout = q.pop_front();
         m_vld = m_rd;
         if (m_wr) q.push_back(din);
         m_ov = new_ov || (m_ov && !clr_err);
         m_un = new_un || (m_un && !clr_err);
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int wr_idx;
      int rd_idx;

      // Reset state
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      chk("reset_count", 32'(bus_std.count), 0);
      chk("reset_ae", 32'(bus_std.almost_empty), 1);

      // Fill to full, then one rejected write
      w_en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         din = 8'(i);
         cycle();
         if (i == 12) chk("af_rise", 32'(bus_std.almost_full), 1);
      end
      chk("full_after_16", 32'(bus_std.full), 1);
      din = 8'hAA;
      cycle();
      chk("overflow_17th", 32'(bus_std.overflow), 1);
      w_en = 1'b0;

      // Drain in order with one-cycle latency
      r_en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         cycle();
         chk("drain_order", 32'(bus_std.dout), i);
         if (i == 12) chk("ae_rise", 32'(bus_std.almost_empty), 1);
      end
      r_en = 1'b0;
      chk("drained_empty", 32'(bus_std.empty), 1);

      // Simultaneous read and write at full
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;
      w_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din = 8'(8'h20 + i);
         cycle();
      end
      din  = 8'h55;
      r_en = 1'b1;
      cycle();
      chk("simul_count", 32'(bus_std.count), 16);
      chk("simul_pop", 32'(bus_std.dout), 32'h20);
      w_en = 1'b0;
      for (int i = 0; i < 16; i++) cycle();
      chk("simul_last", 32'(bus_std.dout), 32'h55);
      r_en = 1'b0;

      // Underflow, clear, then write+read at empty
      r_en = 1'b1;
      cycle();
      chk("underflow_set", 32'(bus_std.underflow), 1);
      r_en = 1'b0;
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;
      chk("underflow_clr", 32'(bus_std.underflow), 0);
      w_en = 1'b1;
      r_en = 1'b1;
      din  = 8'h77;
      cycle();
      chk("empty_wr_rd_count", 32'(bus_std.count), 1);
      chk("empty_wr_rd_un", 32'(bus_std.underflow), 1);
      w_en = 1'b0;
      cycle();
      r_en = 1'b0;
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;

      // Random stream of 40 words across pointer wraps
      wr_idx = 0;
      rd_idx = 0;
      for (int c = 0; c < 2000 && rd_idx < 40; c++) begin
         w_en = (wr_idx < 40) && ($urandom_range(0, 1) == 1);
         r_en = ($urandom_range(0, 1) == 1);
         din  = 8'(wr_idx);
         cycle();
         if (m_wr) wr_idx++;
         if (bus_std.dout_valid) begin
            chk("stream_order", 32'(bus_std.dout), rd_idx);
            rd_idx++;
         end
         chk("stream_count", 32'(bus_std.count), wr_idx - rd_idx);
      end
      chk("stream_done", rd_idx, 40);
      w_en = 1'b0;
      r_en = 1'b0;
      clr_err = 1'b1;
      cycle();
      clr_err = 1'b0;

      // FWFT fall-through, pop, then reset mid-stream
      w_en = 1'b1;
      din  = 8'h3C;
      cycle();
      w_en = 1'b0;
      chk("fwft_show_dout", 32'(bus_fw.dout), 32'h3C);
      chk("fwft_show_valid", 32'(bus_fw.dout_valid), 1);
      r_en = 1'b1;
      cycle();
      chk("fwft_pop_empty", 32'(bus_fw.empty), 1);
      cycle();
      r_en = 1'b0;
      w_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         din = 8'(8'h60 + i);
         cycle();
      end
      chk("pre_reset_count", 32'(bus_fw.count), 7);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      w_en = 1'b0;
      chk("mid_reset_count", 32'(bus_fw.count), 0);
      chk("mid_reset_empty", 32'(bus_fw.empty), 1);
      chk("mid_reset_un", 32'(bus_fw.underflow), 0);
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
